// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program load port, control
// inputs from hazard/branch/debug units and IF/ID outputs.
interface instruction_fetch_if #(
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int ADDR_BITS        = 8
);
  logic                        i_load_en;
  logic [ADDR_BITS-1:0]        i_load_addr;
  logic [INSTRUCTION_BITS-1:0] i_load_data;
  logic                        i_start;
  logic                        i_enable;
  logic                        i_pc_write;
  logic                        i_branch_taken;
  logic [PC_BITS-1:0]          i_branch_addr;
  logic                        i_flush;
  logic [PC_BITS-1:0]          o_pc;
  logic [PC_BITS-1:0]          o_PCNext;
  logic [INSTRUCTION_BITS-1:0] o_instruction;
  logic                        o_if_id_write;
  logic                        o_halted;

  modport master (
    output i_load_en, i_load_addr, i_load_data,
    output i_start, i_enable, i_pc_write,
    output i_branch_taken, i_branch_addr, i_flush,
    input  o_pc, o_PCNext, o_instruction,
    input  o_if_id_write, o_halted
  );

  modport slave (
    input  i_load_en, i_load_addr, i_load_data,
    input  i_start, i_enable, i_pc_write,
    input  i_branch_taken, i_branch_addr, i_flush,
    output o_pc, o_PCNext, o_instruction,
    output o_if_id_write, o_halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, async-read instruction memory and
// LOAD/RUN/HALTED program lifecycle feeding IF/ID.
module instruction_fetch #(
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int ADDR_BITS        = 8,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = '1,
  parameter logic [INSTRUCTION_BITS-1:0] NOP_WORD  = '0
) (
  input  logic clk,
  input  logic rst,
  instruction_fetch_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_e;

  state_e state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [INSTRUCTION_BITS-1:0] mem_q [DEPTH];
  logic [INSTRUCTION_BITS-1:0] rd_word;
  logic halt_hit;
  logic mem_we;

  assign rd_word = mem_q[pc_q[ADDR_BITS-1:0]];

  assign halt_hit = (rd_word == HALT_WORD)
                  && !bus.i_flush
                  && bus.i_pc_write;

  // Reset in the same cycle drops a pending load.
  assign mem_we = (state_q == S_LOAD)
                && bus.i_load_en
                && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.i_load_addr] <= bus.i_load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_LOAD, S_HALT: begin
        if (bus.i_start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (bus.i_enable) begin
          if (bus.i_branch_taken) begin
            pc_d = bus.i_branch_addr;
          end else if (halt_hit) begin
            state_d = S_HALT;
          end else if (bus.i_pc_write) begin
            pc_d = pc_q + PC_BITS'(1);
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    bus.o_instruction = NOP_WORD;
    bus.o_if_id_write = 1'b0;
    bus.o_halted      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (!bus.i_flush) begin
          bus.o_instruction = rd_word;
        end
        // A redirect writes IF/ID even under a stall.
        bus.o_if_id_write = bus.i_enable
                          && (bus.i_branch_taken
                           || bus.i_pc_write);
      end
      S_HALT: begin
        bus.o_halted      = 1'b1;
        bus.o_if_id_write = bus.i_enable;
      end
      default: begin
        bus.o_instruction = NOP_WORD;
      end
    endcase
  end

  assign bus.o_pc     = pc_q;
  assign bus.o_PCNext = pc_q + PC_BITS'(1);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch
// against a cycle-level program-lifecycle model.
module tb_instruction_fetch;
  localparam int PB = 32;
  localparam int IB = 32;
  localparam int AB = 8;
  localparam logic [IB-1:0] HALT = 32'hFFFF_FFFF;
  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(
    .PC_BITS(PB),
    .INSTRUCTION_BITS(IB),
    .ADDR_BITS(AB)
  ) bus ();

  instruction_fetch #(
    .PC_BITS(PB),
    .INSTRUCTION_BITS(IB),
    .ADDR_BITS(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  int            mode;
  logic [PB-1:0] mpc;
  logic [IB-1:0] mmem [1 << AB];

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic r, input logic le,
    input logic [AB-1:0] la, input logic [IB-1:0] ld,
    input logic st, input logic en, input logic pw,
    input logic br, input logic [PB-1:0] ba,
    input logic fl);
    rst                = r;
    bus.i_load_en      = le;
    bus.i_load_addr    = la;
    bus.i_load_data    = ld;
    bus.i_start        = st;
    bus.i_enable       = en;
    bus.i_pc_write     = pw;
    bus.i_branch_taken = br;
    bus.i_branch_addr  = ba;
    bus.i_flush        = fl;
  endtask

  task automatic run(input logic en, input logic pw);
    drive(0, 0, 0, 0, 0, en, pw, 0, 0, 0);
  endtask

  task automatic jump(input logic [PB-1:0] a);
    drive(0, 0, 0, 0, 0, 1, 1, 1, a, 0);
  endtask

  task automatic model_check();
    logic [IB-1:0] word;
    logic          stalled;
    logic [IB-1:0] e_ins;
    logic          e_wr;
    word    = mmem[mpc[AB-1:0]];
    stalled = !bus.i_pc_write && !bus.i_branch_taken;
    e_ins = (mode == M_RUN && !bus.i_flush) ? word : '0;
    if (mode == M_RUN)
      e_wr = bus.i_enable && !stalled;
    else if (mode == M_HALT)
      e_wr = bus.i_enable;
    else
      e_wr = 1'b0;
    chk("pc", bus.o_pc, mpc);
    chk("pcnext", bus.o_PCNext, mpc + 32'd1);
    chk("instr", bus.o_instruction, e_ins);
    chk("ifid_wr", 32'(bus.o_if_id_write), 32'(e_wr));
    chk("halted", 32'(bus.o_halted),
        32'(mode == M_HALT));
  endtask

  task automatic model_update();
    logic [IB-1:0] word;
    word = mmem[mpc[AB-1:0]];
    if (rst) begin
      mode = M_LOAD;
      mpc  = '0;
    end else if (mode == M_LOAD) begin
      if (bus.i_load_en)
        mmem[bus.i_load_addr] = bus.i_load_data;
      if (bus.i_start) begin
        mode = M_RUN;
        mpc  = '0;
      end
    end else if (mode == M_HALT) begin
      if (bus.i_start) begin
        mode = M_RUN;
        mpc  = '0;
      end
    end else if (bus.i_enable) begin
      if (bus.i_branch_taken)
        mpc = bus.i_branch_addr;
      else if (word == HALT && !bus.i_flush
               && bus.i_pc_write)
        mode = M_HALT;
      else if (bus.i_pc_write)
        mpc = mpc + 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    logic [IB-1:0] v;
    logic [PB-1:0] ba;
    for (int i = 0; i < (1 << AB); i++) mmem[i] = '0;
    mode = M_LOAD;
    mpc  = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    settle();
    chk("rst_pcnext", bus.o_PCNext, 32'd1);
    chk("rst_wr", 32'(bus.o_if_id_write), 0);
    chk("rst_halt", 32'(bus.o_halted), 0);
    tick();

    // Fill the whole memory; last write also starts.
    for (int i = 0; i < (1 << AB); i++) begin
      v = $urandom;
      if (v == HALT) v = 0;
      if (i == 0) v = 32'h11;
      if (i == 1) v = 32'h22;
      if (i == 2) v = 32'h33;
      if (i == 3) v = HALT;
      drive(0, 1, AB'(i), v,
            i == (1 << AB) - 1, 1, 1, 0, 0, 0);
      cyc();
    end

    run(1, 1);
    settle();
    chk("seq_i0", bus.o_instruction, 32'h11);
    chk("seq_n0", bus.o_PCNext, 32'd1);
    tick();
    settle();
    chk("seq_i1", bus.o_instruction, 32'h22);
    chk("seq_n1", bus.o_PCNext, 32'd2);
    tick();
    settle();
    chk("seq_i2", bus.o_instruction, 32'h33);
    chk("seq_n2", bus.o_PCNext, 32'd3);
    tick();
    settle();
    chk("halt_ins", bus.o_instruction, HALT);
    chk("halt_wr", 32'(bus.o_if_id_write), 1);
    tick();
    settle();
    chk("halted", 32'(bus.o_halted), 1);
    chk("halted_pc", bus.o_pc, 32'd3);
    chk("halted_nop", bus.o_instruction, 0);
    tick();
    cyc();

    // Stall at PC=1.
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    cyc();
    run(1, 1);
    cyc();
    run(1, 0);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("stall_pc", bus.o_pc, 32'd1);
      chk("stall_wr", 32'(bus.o_if_id_write), 0);
      tick();
    end
    run(1, 1);
    cyc();
    settle();
    chk("resume_pc", bus.o_pc, 32'd2);
    tick();

    // Redirect with stall and flush at PC=1.
    jump(1);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 32'h40, 1);
    settle();
    chk("flush_nop", bus.o_instruction, 0);
    chk("redir_wr", 32'(bus.o_if_id_write), 1);
    tick();
    settle();
    chk("redir_pc", bus.o_pc, 32'h40);
    tick();

    // Step gate from PC=0: 1,0,0,1.
    jump(0);
    cyc();
    run(1, 1);
    cyc();
    run(0, 1);
    cyc();
    cyc();
    run(1, 1);
    cyc();
    settle();
    chk("gate_pc", bus.o_pc, 32'd2);
    tick();

    // Load attempt while running is ignored.
    drive(0, 1, 2, 32'hAA, 0, 1, 0, 0, 0, 0);
    cyc();
    jump(2);
    cyc();
    run(1, 0);
    settle();
    chk("guard_ld", bus.o_instruction, 32'h33);
    tick();

    // PC wrap-around.
    jump('1);
    cyc();
    run(1, 1);
    settle();
    chk("wrap_next", bus.o_PCNext, 0);
    tick();
    settle();
    chk("wrap_pc", bus.o_pc, 0);
    tick();

    // Reset mid-run with a pending redirect.
    jump(5);
    cyc();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 32'h77, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    settle();
    chk("rst_pc", bus.o_pc, 0);
    chk("rst_wr2", 32'(bus.o_if_id_write), 0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    cyc();
    jump(2);
    cyc();
    run(1, 0);
    settle();
    chk("mem_kept", bus.o_instruction, 32'h33);
    tick();

    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      ba = ($urandom_range(0, 15) == 0)
         ? PB'($urandom)
         : PB'($urandom_range(0, 300));
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            AB'($urandom), v,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0,
            ba,
            $urandom_range(0, 7) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that drives the IF/ID pipeline register: holds the PC and an internal instruction memory with asynchronous read.
- Each cycle presents the instruction at PC, PC+1 and the IF/ID write strobe.
- Owns the program lifecycle: LOAD (memory write) → RUN → HALTED.
- Honours hazard stalls, branch/jump redirects, flushes and a debug step gate.

Parameters:
- PC_BITS, 32, PC and PC-next width; PC is word-addressed, +1 per instruction.
- INSTRUCTION_BITS, 32, instruction width.
- ADDR_BITS, 8, instruction memory address width; depth is 2**ADDR_BITS words.
- HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch.
- NOP_WORD, 32'h00000000, bubble inserted on flush or when not running.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_load_en  in  1  write i_load_data to memory at i_load_addr (LOAD state only).
- i_load_addr  in  ADDR_BITS  memory write address.
- i_load_data  in  INSTRUCTION_BITS  memory write data.
- i_start  in  1  LOAD/HALTED → RUN, PC := 0.
- i_enable  in  1  step gate from the debug unit; 0 freezes all fetch state.
- i_pc_write  in  1  hazard unit: 1 = advance, 0 = stall.
- i_branch_taken  in  1  redirect request from a later stage.
- i_branch_addr  in  PC_BITS  redirect target.
- i_flush  in  1  replace the current fetch with NOP_WORD.
- o_pc  out  PC_BITS  current PC.
- o_PCNext  out  PC_BITS  PC+1, modulo 2**PC_BITS; goes to IF/ID i_PCNext.
- o_instruction  out  INSTRUCTION_BITS  goes to IF/ID i_instruction.
- o_if_id_write  out  1  goes to IF/ID i_if_id_write.
- o_halted  out  1  high in the HALTED state.

Behaviour:
- Reset:
  - state=LOAD, PC=0, o_halted=0.
  - Memory contents are not cleared; they are retained across reset.
  - Outputs during LOAD: o_instruction=NOP_WORD, o_if_id_write=0, o_PCNext=1.
- Memory:
  - Read is combinational: mem[PC[ADDR_BITS-1:0]].
  - Upper PC bits are ignored, so the address aliases/wraps.
  - Writes happen only when state=LOAD and i_load_en; they are ignored in RUN and HALTED.
  - A same-cycle write and read shows the old data; the new word is visible next cycle.
- LOAD:
  - i_start → RUN with PC:=0.
  - i_start and i_load_en in the same cycle: the write completes and the transition occurs.
- RUN, i_enable=0:
  - PC and state are held; o_if_id_write=0.
- RUN, i_enable=1, priority order:
  1. i_branch_taken: PC := i_branch_addr; o_if_id_write=1. A redirect overrides both a stall and a halt detect. o_instruction is NOP_WORD if i_flush, else mem[PC].
  2. mem[PC]==HALT_WORD and !i_flush and i_pc_write: present HALT_WORD, o_if_id_write=1, PC held, next state=HALTED.
  3. i_pc_write=1: PC := PC+1; o_if_id_write=1.
  4. i_pc_write=0 (stall): PC held; o_if_id_write=0, so IF/ID keeps its contents.
- Instruction and PC-next outputs:
  - o_instruction = NOP_WORD when i_flush=1 or state≠RUN; otherwise mem[PC].
  - o_PCNext is always o_pc+1, combinational.
- HALTED:
  - o_halted=1, PC frozen at the halt address.
  - o_instruction=NOP_WORD; o_if_id_write=i_enable, so the pipeline drains with bubbles.
  - i_start → RUN with PC:=0.
  - Only rst returns to LOAD.
- Wrap-around: PC = 2**PC_BITS-1 advances to 0.
- Reset mid-operation: any state goes to LOAD within one edge; a pending redirect or load is dropped.

Test Plan:
- Reset, then load mem[0..3]={0x11,0x22,0x33,HALT_WORD}, then i_start, all enables=1:
  - o_instruction is 0x11, 0x22, 0x33 on consecutive cycles, with o_PCNext 1, 2, 3.
  - HALT_WORD is presented once with write=1.
  - o_halted=1 next cycle, o_pc=3, then NOPs follow.
- Stall: i_pc_write=0 for 2 cycles at PC=1 → o_pc stays 1, o_if_id_write=0 for both cycles; resumes to 2 afterwards.
- Redirect:
  - At PC=1, i_branch_taken=1, i_branch_addr=0x40, i_pc_write=0 → next o_pc=0x40.
  - Same cycle with i_flush=1 → o_instruction=NOP_WORD.
- Step gate: i_enable toggling 1,0,0,1 from PC=0 → o_pc sequence 0,1,1,1,2; o_if_id_write=1 only when enabled.
- Guarded load: i_load_en during RUN at addr 2 with data 0xAA → mem[2] unchanged (still 0x33 when fetched).
- Boundaries:
  - Force PC to 2**PC_BITS-1 via redirect → next PC=0.
  - rst asserted while RUN at PC=5 → next cycle state=LOAD, o_pc=0, o_if_id_write=0, memory intact.
